// File: rtl/pong_match_controller.sv
// Pong match sequencer: debounced pause/start key, scores, serve side and game-flow FSM; all outputs registered (1 cycle).
// PONG_AUTO_SERVE_EN: when defined, GOAL returns straight to SERVE instead of IDLE after the hold.
module pong_match_controller #(
    parameter int WIN_SCORE       = 7,
    parameter int GOAL_HOLD_TICKS = 60,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       CLOCK_25,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       key_pause,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       run,
    output logic       serve,
    output logic       serve_side,
    output logic [2:0] score_1,
    output logic [2:0] score_2,
    output logic       goal_player_1,
    output logic       goal_player_2,
    output logic       win_player_1,
    output logic       win_player_2,
    output logic [2:0] state
);

    localparam int             CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]     GOAL_LAST = 8'(GOAL_HOLD_TICKS - 1);
    localparam logic [2:0]     WIN_VAL   = 3'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_PAUSED = 3'd3,
        S_GOAL   = 3'd4,
        S_WIN    = 3'd5
    } match_state_t;

    match_state_t  cur_state;
    logic          key_meta;
    logic          key_sync;
    logic          key_level;
    logic [CW-1:0] db_cnt;
    logic          press;
    logic [7:0]    goal_cnt;
    logic [2:0]    score_1_inc;
    logic [2:0]    score_2_inc;

    assign score_1_inc = score_1 + 3'd1;
    assign score_2_inc = score_2 + 3'd1;
    assign state       = cur_state;

    // Key idles high (active-low button), so the synchronizer and accepted level reset to 1.
    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_pause;
            key_sync <= key_meta;
        end
    end

    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            key_level <= 1'b1;
            db_cnt    <= '0;
            press     <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_sync == key_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_level <= key_sync;
                db_cnt    <= '0;
                press     <= ~key_sync;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            cur_state     <= S_IDLE;
            run           <= 1'b0;
            serve         <= 1'b0;
            serve_side    <= 1'b0;
            score_1       <= 3'd0;
            score_2       <= 3'd0;
            goal_player_1 <= 1'b0;
            goal_player_2 <= 1'b0;
            win_player_1  <= 1'b0;
            win_player_2  <= 1'b0;
            goal_cnt      <= 8'd0;
        end else begin
            serve <= 1'b0;
            case (cur_state)
                S_IDLE: begin
                    if (press) cur_state <= S_SERVE;
                end
                S_SERVE: begin
                    if (tick) begin
                        cur_state <= S_PLAY;
                        serve     <= 1'b1;
                        run       <= 1'b1;
                    end
                end
                S_PLAY: begin
                    // Misses outrank a same-cycle press; a double miss is a replay.
                    if (miss_left && miss_right) begin
                        cur_state <= S_SERVE;
                        run       <= 1'b0;
                    end else if (miss_left) begin
                        score_2    <= score_2_inc;
                        serve_side <= 1'b0;
                        run        <= 1'b0;
                        goal_cnt   <= 8'd0;
                        if (score_2_inc == WIN_VAL) begin
                            cur_state    <= S_WIN;
                            win_player_2 <= 1'b1;
                        end else begin
                            cur_state     <= S_GOAL;
                            goal_player_2 <= 1'b1;
                        end
                    end else if (miss_right) begin
                        score_1    <= score_1_inc;
                        serve_side <= 1'b1;
                        run        <= 1'b0;
                        goal_cnt   <= 8'd0;
                        if (score_1_inc == WIN_VAL) begin
                            cur_state    <= S_WIN;
                            win_player_1 <= 1'b1;
                        end else begin
                            cur_state     <= S_GOAL;
                            goal_player_1 <= 1'b1;
                        end
                    end else if (press) begin
                        cur_state <= S_PAUSED;
                        run       <= 1'b0;
                    end
                end
                S_PAUSED: begin
                    if (press) begin
                        cur_state <= S_PLAY;
                        run       <= 1'b1;
                    end
                end
                S_GOAL: begin
                    if (tick) begin
                        if (goal_cnt == GOAL_LAST) begin
                            goal_cnt      <= 8'd0;
                            goal_player_1 <= 1'b0;
                            goal_player_2 <= 1'b0;
`ifdef PONG_AUTO_SERVE_EN
                            cur_state     <= S_SERVE;
`else
                            cur_state     <= S_IDLE;
`endif
                        end else begin
                            goal_cnt <= goal_cnt + 8'd1;
                        end
                    end
                end
                S_WIN: begin
                    if (press) begin
                        score_1      <= 3'd0;
                        score_2      <= 3'd0;
                        win_player_1 <= 1'b0;
                        win_player_2 <= 1'b0;
                        cur_state    <= S_SERVE;
                    end
                end
                default: begin
                    cur_state <= S_IDLE;
                    run       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_controller.sv
// Scoreboarded bench: event-level match model predicts each visible output change; a monitor compares every change.
module tb_pong_match_controller;

    localparam int DB   = 32;
    localparam int HOLD = 60;
    localparam int WINS = 7;
    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_PAUSED = 3, M_GOAL = 4, M_WIN = 5;

    logic       CLOCK_25 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       tick = 1'b0, key_pause = 1'b1, miss_left = 1'b0, miss_right = 1'b0;
    logic       run, serve, serve_side;
    logic [2:0] score_1, score_2, state;
    logic       goal_player_1, goal_player_2, win_player_1, win_player_2;

    pong_match_controller #(
        .WIN_SCORE(WINS), .GOAL_HOLD_TICKS(HOLD), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLOCK_25(CLOCK_25), .reset_n(reset_n), .tick(tick), .key_pause(key_pause),
        .miss_left(miss_left), .miss_right(miss_right), .run(run), .serve(serve),
        .serve_side(serve_side), .score_1(score_1), .score_2(score_2),
        .goal_player_1(goal_player_1), .goal_player_2(goal_player_2),
        .win_player_1(win_player_1), .win_player_2(win_player_2), .state(state)
    );

    always #5 CLOCK_25 = ~CLOCK_25;

    // Reference model: match state expressed as the game's rules, one event at a time.
    int  m_state;
    bit  m_run, m_serve, m_side;
    int  m_score [1:2];
    bit  m_goal [1:2];
    bit  m_win [1:2];
    int  m_gticks;
    logic [15:0] last_snap;
    logic [15:0] exp_q[$];
    bit  done = 1'b0;
    int  total = 0;
    int  bad = 0;

    function automatic logic [15:0] model_snap();
        return {3'(m_state), m_run, m_serve, m_side, 3'(m_score[1]), 3'(m_score[2]),
                m_goal[1], m_goal[2], m_win[1], m_win[2]};
    endfunction

    function automatic void push_model();
        logic [15:0] s;
        s = model_snap();
        if (s != last_snap) begin
            exp_q.push_back(s);
            last_snap = s;
        end
    endfunction

    function automatic void model_reset();
        m_state = M_IDLE; m_run = 0; m_serve = 0; m_side = 0; m_gticks = 0;
        for (int p = 1; p <= 2; p++) begin
            m_score[p] = 0; m_goal[p] = 0; m_win[p] = 0;
        end
        push_model();
    endfunction

    function automatic void model_event(input bit p, input bit ml, input bit mr, input bit t);
        int scorer;
        case (m_state)
            M_IDLE:   if (p) m_state = M_SERVE;
            M_SERVE:  if (t) begin
                m_state = M_PLAY; m_run = 1; m_serve = 1;
                push_model();
                m_serve = 0;
            end
            M_PLAY: begin
                if (ml && mr) begin
                    m_state = M_SERVE; m_run = 0;
                end else if (ml || mr) begin
                    scorer = ml ? 2 : 1;
                    m_score[scorer] = (m_score[scorer] + 1) % 8;
                    m_side = (scorer == 1);
                    m_run = 0;
                    m_gticks = 0;
                    if (m_score[scorer] == WINS) begin
                        m_state = M_WIN; m_win[scorer] = 1;
                    end else begin
                        m_state = M_GOAL; m_goal[scorer] = 1;
                    end
                end else if (p) begin
                    m_state = M_PAUSED; m_run = 0;
                end
            end
            M_PAUSED: if (p) begin m_state = M_PLAY; m_run = 1; end
            M_GOAL: if (t) begin
                m_gticks++;
                if (m_gticks == HOLD) begin
                    m_goal[1] = 0; m_goal[2] = 0;
`ifdef PONG_AUTO_SERVE_EN
                    m_state = M_SERVE;
`else
                    m_state = M_IDLE;
`endif
                end
            end
            M_WIN: if (p) begin
                m_score[1] = 0; m_score[2] = 0; m_win[1] = 0; m_win[2] = 0;
                m_state = M_SERVE;
            end
            default: ;
        endcase
        push_model();
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLOCK_25);
        #1;
    endtask

    task automatic drive_cycle(input bit t, input bit ml, input bit mr);
        @(posedge CLOCK_25); #1;
        tick = t; miss_left = ml; miss_right = mr;
        @(posedge CLOCK_25); #1;
        tick = 0; miss_left = 0; miss_right = 0;
        model_event(0, ml, mr, t);
        wait_cycles(1);
    endtask

    task automatic press_key();
        @(posedge CLOCK_25); #1;
        key_pause = 0;
        model_event(1, 0, 0, 0);
        wait_cycles(DB + 6);
        key_pause = 1;
        wait_cycles(DB + 6);
    endtask

    task automatic bounce_key();
        for (int i = 0; i < 20; i++) begin
            @(posedge CLOCK_25); #1;
            key_pause = 1'($urandom_range(0, 1));
        end
        key_pause = 1;
        wait_cycles(DB + 6);
    endtask

    task automatic to_play();
        int n = 0;
        while (m_state != M_PLAY && n < 200) begin
            if (m_state == M_IDLE || m_state == M_PAUSED || m_state == M_WIN) press_key();
            else drive_cycle(1, 0, 0);
            n++;
        end
    endtask

    task automatic hit_reset();
        @(posedge CLOCK_25); #3;
        reset_n = 0;
        model_reset();
        wait_cycles(3);
        #2 reset_n = 1;
        wait_cycles(2);
    endtask

    // Monitor: every visible output change must match the next predicted snapshot.
    initial begin : monitor
        logic [15:0] cur, prev, e;
        #2;
        cur = {state, run, serve, serve_side, score_1, score_2,
               goal_player_1, goal_player_2, win_player_1, win_player_2};
        total++;
        if (cur !== 16'h0) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", cur, 16'h0);
        end
        prev = cur;
        while (!done) begin
            @(negedge CLOCK_25 or negedge reset_n or posedge done);
            #1;
            cur = {state, run, serve, serve_side, score_1, score_2,
                   goal_player_1, goal_player_2, win_player_1, win_player_2};
            if (cur !== prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change got=%h want=no_change t=%0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        bad++;
                        $display("FAIL snapshot got=%h want=%h t=%0t", cur, e, $time);
                    end
                end
                prev = cur;
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_expect got=%0d_left want=0 next=%h", exp_q.size(), exp_q[0]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int r;
        last_snap = 16'h0;
        model_reset();
        #22 reset_n = 1;
        wait_cycles(2);

        press_key();
        drive_cycle(1, 0, 0);
        drive_cycle(0, 0, 1);
        for (int i = 0; i < HOLD + 2; i++) drive_cycle(1, 0, 0);

        to_play();
        bounce_key();
        press_key();
        drive_cycle(0, 1, 0);
        press_key();

        while (m_score[1] < 6) begin
            to_play();
            drive_cycle(0, 0, 1);
        end
        to_play();
        drive_cycle(1, 0, 1);
        press_key();

        to_play();
        drive_cycle(0, 1, 1);

        to_play();
        drive_cycle(1, 1, 0);
        for (int i = 0; i < 5; i++) drive_cycle(1, 0, 0);
        hit_reset();

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50)      drive_cycle(1, 0, 0);
            else if (r < 62) press_key();
            else if (r < 74) drive_cycle(0, 1, 0);
            else if (r < 86) drive_cycle(0, 0, 1);
            else if (r < 91) drive_cycle(0, 1, 1);
            else if (r < 97) drive_cycle(1, r[0], ~r[0]);
            else             hit_reset();
        end

        wait_cycles(10);
        done = 1'b1;
    end

endmodule
